// File: rtl/fu_cdb_queue_if.sv
// Handshake bundle between a functional unit, the branch unit and the CDB arbiter.
// The master side drives the FU/branch/grant inputs; the slave side is the completion queue.
interface fu_cdb_queue_if #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 6,
  parameter int BMASK_W = 4,
  parameter int BSPTR_W = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               fu_done;
  logic [DATA_W-1:0]  fu_result;
  logic [TAG_W-1:0]   fu_tagDest;
  logic [BMASK_W-1:0] fu_bmask;
  logic               cdb_grant;
  logic               br_branch_resolved;
  logic               br_pred_wrong;
  logic [BSPTR_W-1:0] br_bs_ptr;
  logic               fub_busy;
  logic               fub_valid;
  logic [DATA_W-1:0]  fub_result;
  logic [TAG_W-1:0]   fub_tagDest;
  logic [BMASK_W-1:0] fub_bmask;
  logic [CNT_W-1:0]   fub_count;

  modport master (
    output fu_done, fu_result, fu_tagDest, fu_bmask, cdb_grant,
           br_branch_resolved, br_pred_wrong, br_bs_ptr,
    input  fub_busy, fub_valid, fub_result, fub_tagDest, fub_bmask, fub_count
  );

  modport slave (
    input  fu_done, fu_result, fu_tagDest, fu_bmask, cdb_grant,
           br_branch_resolved, br_pred_wrong, br_bs_ptr,
    output fub_busy, fub_valid, fub_result, fub_tagDest, fub_bmask, fub_count
  );
endinterface

// File: rtl/fu_cdb_queue.sv
// In-order, self-compacting completion queue between one FU and the CDB arbiter.
// Squashed entries vanish in the cycle of the mispredict; a squashed head is never shown valid.
module fu_cdb_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 6,
  parameter int BMASK_W = 4,
  parameter int BSPTR_W = 2
) (
  input logic           clk,
  input logic           reset,
  fu_cdb_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]   r_valid;
  logic [DATA_W-1:0]  r_result [DEPTH];
  logic [TAG_W-1:0]   r_tag    [DEPTH];
  logic [BMASK_W-1:0] r_bmask  [DEPTH];
  logic [CNT_W-1:0]   r_count;

  logic               w_kill;
  logic               w_clr;
  logic               w_pop;
  logic               w_busy;
  logic               w_accept;
  logic [BMASK_W-1:0] w_bit;
  logic [BMASK_W-1:0] w_clrmask;
  logic [DEPTH-1:0]   w_sq;
  logic [DEPTH-1:0]   w_keep;
  logic [CNT_W-1:0]   w_pos [DEPTH];
  logic [CNT_W-1:0]   w_nkeep;
  logic [DEPTH-1:0]   w_sel [DEPTH];
  logic [DEPTH-1:0]   w_sel_in;
  logic [DEPTH-1:0]   w_nxt_valid;
  logic [DATA_W-1:0]  w_nxt_result [DEPTH];
  logic [TAG_W-1:0]   w_nxt_tag    [DEPTH];
  logic [BMASK_W-1:0] w_nxt_bmask  [DEPTH];
  logic [CNT_W-1:0]   w_nxt_count;

  assign w_bit     = {{(BMASK_W-1){1'b0}}, 1'b1} << bus.br_bs_ptr;
  assign w_kill    = bus.br_branch_resolved & bus.br_pred_wrong;
  assign w_clr     = bus.br_branch_resolved & ~bus.br_pred_wrong;
  assign w_clrmask = w_clr ? w_bit : {BMASK_W{1'b0}};

  // Squash detection, pop, back-pressure and acceptance of the incoming result
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sq[i] = w_kill & r_valid[i] & (|(r_bmask[i] & w_bit));
    end
    w_pop     = r_valid[0] & ~w_sq[0] & bus.cdb_grant;
    w_keep    = r_valid & ~w_sq;
    w_keep[0] = w_keep[0] & ~w_pop;
    // count never exceeds DEPTH, so free==0 reduces to "full with nothing leaving"
    w_busy    = (r_count == CNT_W'(DEPTH)) & ~w_pop & ~(|w_sq);
    w_accept  = bus.fu_done & ~w_busy & ~(w_kill & (|(bus.fu_bmask & w_bit)));
  end

  // Destination index of each survivor: number of survivors older than it
  always_comb begin
    w_pos[0] = {CNT_W{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      w_pos[i] = w_pos[i-1] + CNT_W'(w_keep[i-1]);
    end
    w_nkeep     = w_pos[DEPTH-1] + CNT_W'(w_keep[DEPTH-1]);
    w_nxt_count = w_nkeep + CNT_W'(w_accept);
  end

  // Compaction as an AND-OR mux: slot j takes survivor i when its position is j, else the new entry
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_sel_in[j]     = w_accept & (w_nkeep == CNT_W'(j));
      w_nxt_valid[j]  = w_sel_in[j];
      w_nxt_result[j] = {DATA_W{w_sel_in[j]}} & bus.fu_result;
      w_nxt_tag[j]    = {TAG_W{w_sel_in[j]}} & bus.fu_tagDest;
      w_nxt_bmask[j]  = {BMASK_W{w_sel_in[j]}} & bus.fu_bmask;
      for (int i = 0; i < DEPTH; i++) begin
        w_sel[j][i]     = w_keep[i] & (w_pos[i] == CNT_W'(j));
        w_nxt_valid[j]  = w_nxt_valid[j] | w_sel[j][i];
        w_nxt_result[j] = w_nxt_result[j] | ({DATA_W{w_sel[j][i]}} & r_result[i]);
        w_nxt_tag[j]    = w_nxt_tag[j] | ({TAG_W{w_sel[j][i]}} & r_tag[i]);
        w_nxt_bmask[j]  = w_nxt_bmask[j] | ({BMASK_W{w_sel[j][i]}} & r_bmask[i]);
      end
      w_nxt_bmask[j] = w_nxt_bmask[j] & ~w_clrmask;
    end
  end

  // Queue state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= {DEPTH{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int j = 0; j < DEPTH; j++) begin
        r_result[j] <= {DATA_W{1'b0}};
        r_tag[j]    <= {TAG_W{1'b0}};
        r_bmask[j]  <= {BMASK_W{1'b0}};
      end
    end else begin
      r_valid <= w_nxt_valid;
      r_count <= w_nxt_count;
      for (int j = 0; j < DEPTH; j++) begin
        r_result[j] <= w_nxt_result[j];
        r_tag[j]    <= w_nxt_tag[j];
        r_bmask[j]  <= w_nxt_bmask[j];
      end
    end
  end

  assign bus.fub_valid   = r_valid[0] & ~w_sq[0];
  assign bus.fub_result  = r_result[0];
  assign bus.fub_tagDest = r_tag[0];
  assign bus.fub_bmask   = r_bmask[0] & ~w_clrmask;
  assign bus.fub_busy    = w_busy;
  assign bus.fub_count   = r_count;
endmodule

// File: doc/fu_cdb_queue.md
Name: fu_cdb_queue

Overview:
- Parametrised, in-order completion queue between one functional unit and the CDB arbiter.
- Replaces the fixed two-entry FU output buffer: depth is configurable, and the queue compacts itself.
- Squashes any subset of entries on a branch mispredict, and clears the resolved branch bit on a correct prediction.
- Masks a squashed head in the same cycle, so a wrong-path result is never broadcast.

Parameters:
- DEPTH, 4, number of entries (>=2).
- DATA_W, 64, result width.
- TAG_W, 6, physical register tag width.
- BMASK_W, 4, branch mask width (one bit per branch stack slot).
- BSPTR_W, 2, branch stack pointer width, $clog2(BMASK_W).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fu_done  in  1  FU presents a completed result this cycle.
- fu_result  in  DATA_W  result value.
- fu_tagDest  in  TAG_W  destination physical register.
- fu_bmask  in  BMASK_W  branch dependence mask of the result.
- cdb_grant  in  1  CDB accepts the head this cycle.
- br_branch_resolved  in  1  a branch resolves this cycle.
- br_pred_wrong  in  1  the resolved branch mispredicted (qualified by br_branch_resolved).
- br_bs_ptr  in  BSPTR_W  branch stack slot of the resolving branch.
- fub_busy  out  1  queue cannot accept fu_done this cycle; FU must hold its result.
- fub_valid  out  1  head valid and not being squashed.
- fub_result  out  DATA_W  head result.
- fub_tagDest  out  TAG_W  head tag.
- fub_bmask  out  BMASK_W  head mask, with the resolving bit cleared on a correct prediction.
- fub_count  out  $clog2(DEPTH+1)  valid entries held (registered).

Behaviour:
- Storage: DEPTH entries {valid, result, tagDest, bmask}. Index 0 is the oldest (head). Valid entries are always contiguous from index 0.
- Reset: all valid bits clear and fub_count = 0. Hence fub_valid = 0, fub_busy = 0, and the data outputs are don't-care; the bench checks them only when fub_valid = 1.
- Definitions:
  - kill = br_branch_resolved & br_pred_wrong.
  - clr = br_branch_resolved & !br_pred_wrong.
  - sq[i] = kill & entry[i].valid & entry[i].bmask[br_bs_ptr].
- Outputs (combinational from head):
  - fub_valid = entry[0].valid & !sq[0].
  - fub_bmask = entry[0].bmask, with bit br_bs_ptr forced 0 when clr.
- pop = fub_valid & cdb_grant. cdb_grant while fub_valid = 0 is ignored.
- Free slots this cycle: free = DEPTH - fub_count + pop + (number of sq[i]).
- fub_busy = (free == 0), combinational. It is asserted only when the queue is full with no pop and no squash in that cycle.
- Incoming entry (fu_done & !fub_busy):
  - Dropped silently if kill & fu_bmask[br_bs_ptr]. It is not counted and not stored.
  - Stored with bmask bit br_bs_ptr cleared if clr.
- fu_done while fub_busy: not accepted and no state change. The FU holds its result and retries.
- Next state, one cycle:
  1. Remove the popped head and all squashed entries.
  2. Compact the survivors toward index 0, preserving relative age order.
  3. Append the accepted incoming entry at the first free index.
  4. If clr, clear bit br_bs_ptr in every surviving entry.
- Latency: with an empty queue, fu_done at cycle N gives fub_valid = 1 at cycle N+1. There is no same-cycle bypass.
- Throughput: 1 entry per cycle in and 1 per cycle out sustained, including when full: a pop frees a slot in the same cycle, so fub_busy stays 0.
- Simultaneous events:
  - Head granted and squashed in the same cycle: fub_valid = 0, so no broadcast; the entry is removed.
  - A squash that frees slots lowers fub_busy in the same cycle.
  - clr and pop together: the popped head shows the cleared bit on fub_bmask.
- Reset mid-operation: all contents discarded the next cycle; in-flight fu_done is ignored.
- A mispredict with no matching entries leaves the queue unchanged except for the normal pop and append.

Test Plan:
- Fill: DEPTH = 4, cdb_grant = 0, fu_done for 4 cycles with tags 1..4. Required: fub_count = 4, fub_busy = 1, head tag = 1. Then a 5th fu_done with tag 5 is held and not stored.
- Stream while full: queue full, cdb_grant = 1 and fu_done every cycle with tags 5, 6, 7. Required: fub_busy = 0; heads 1, 2, 3 broadcast on consecutive cycles; tags 5, 6, 7 appended in order.
- Selective squash: entries tags 1..4 with bmask 0000, 0010, 0000, 0010; kill with br_bs_ptr = 1. Required next cycle: fub_count = 2 with order 1, 3.
- Head squash race: head bmask 0100, cdb_grant = 1, kill with ptr = 2. Required: fub_valid = 0 that cycle, entry removed, next head promoted.
- Correct prediction: entries bmask 0011 and 0001, plus an incoming entry with bmask 0001, clr with ptr = 0. Required: fub_bmask reads 0010 immediately; stored masks 0010, 0000, 0000.
- Reset mid-stream: reset asserted with 3 entries held and fu_done = 1. Required: next cycle fub_count = 0 and fub_valid = 0.
